// File: rtl/bomb_ctrl.sv
// bomb_ctrl: one player's bomb -- tile snap on drop edge, fuse/blast/cooldown sequencing, blast rectangle.
// Build option BOMB_CROSS_EN: plus-shaped blast (bomb1* = horizontal arm, bomb2* = vertical arm).
module bomb_ctrl #(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLAST_FRAMES    = 30,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int BLAST_RADIUS    = 1,
  parameter int X_MIN           = 32,
  parameter int X_MAX           = 575,
  parameter int Y_MIN           = 32,
  parameter int Y_MAX           = 447,
  parameter int USER_W          = 19,
  parameter int USER_H          = 26
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic       ext_detonate,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  output logic       bomb_armed,
  output logic       bomb_exploding,
  output logic [9:0] bomb_tileX,
  output logic [9:0] bomb_tileY,
  output logic [9:0] bomb1X,
  output logic [9:0] bomb1Y,
  output logic [9:0] bomb1XS,
  output logic [9:0] bomb1YS
`ifdef BOMB_CROSS_EN
  ,
  output logic [9:0] bomb2X,
  output logic [9:0] bomb2Y,
  output logic [9:0] bomb2XS,
  output logic [9:0] bomb2YS
`endif
);

  localparam int MAX_AB = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int MAX_N  = (MAX_AB > COOLDOWN_FRAMES) ? MAX_AB : COOLDOWN_FRAMES;
  localparam int CW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [10:0] REACH  = 11'(BLAST_RADIUS * 32);
  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMIN11 = 11'(Y_MIN);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_EXPLODE, S_COOL} state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] xs;
    logic [9:0] ys;
  } rect_t;

  // One axis of the blast: {origin, extent}. Compare before subtracting so
  // a tile near the low edge clamps instead of wrapping through zero.
  function automatic logic [19:0] f_axis(input logic [9:0] t, input logic [10:0] lim_lo,
                                         input logic [10:0] lim_hi);
    logic [10:0] lo;
    logic [10:0] hi;
    lo = ({1'b0, t} < REACH + lim_lo) ? lim_lo : {1'b0, t} - REACH;
    hi = {1'b0, t} + REACH + 11'd31;
    if (hi > lim_hi) hi = lim_hi;
    f_axis = {10'(lo), 10'(hi - lo)};
  endfunction

  state_t          r_state, w_nstate;
  logic [CW-1:0]   r_cnt, w_ncnt;
  logic            r_drop_d;
  logic [9:0]      r_tileX, r_tileY, w_ntileX, w_ntileY;
  logic            w_drop_edge;
  logic [19:0]     w_ax, w_ay;
  rect_t           w_r1, r_b1;
`ifdef BOMB_CROSS_EN
  rect_t           w_r2, r_b2;
`endif

  assign w_drop_edge = bomb_drop & ~r_drop_d;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ntileX = r_tileX;
    w_ntileY = r_tileY;
    if (r_cnt != '0) w_ncnt = r_cnt - 1'b1;
    case (r_state)
      S_IDLE: begin
        w_ncnt = '0;
        if (w_drop_edge) begin
          w_nstate = S_ARMED;
          w_ncnt   = CW'(FUSE_FRAMES - 1);
          w_ntileX = (userX + 10'(USER_W / 2)) & 10'h3E0;
          w_ntileY = (userY + 10'(USER_H / 2)) & 10'h3E0;
        end
      end
      S_ARMED: begin
        if (ext_detonate || r_cnt == '0) begin
          w_nstate = S_EXPLODE;
          w_ncnt   = CW'(BLAST_FRAMES - 1);
        end
      end
      S_EXPLODE: begin
        if (r_cnt == '0) begin
          w_nstate = S_COOL;
          w_ncnt   = CW'(COOLDOWN_FRAMES - 1);
        end
      end
      S_COOL: begin
        if (r_cnt == '0) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Rectangle is built from the next-state tile so it is ready on the same edge the blast starts.
  always_comb begin
    w_ax = f_axis(w_ntileX, XMIN11, XMAX11);
    w_ay = f_axis(w_ntileY, YMIN11, YMAX11);
`ifdef BOMB_CROSS_EN
    w_r1 = '{x: w_ax[19:10], y: w_ntileY, xs: w_ax[9:0], ys: 10'd31};
    w_r2 = '{x: w_ntileX, y: w_ay[19:10], xs: 10'd31, ys: w_ay[9:0]};
`else
    w_r1 = '{x: w_ax[19:10], y: w_ay[19:10], xs: w_ax[9:0], ys: w_ay[9:0]};
`endif
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_drop_d       <= 1'b0;
      r_tileX        <= '0;
      r_tileY        <= '0;
      bomb_armed     <= 1'b0;
      bomb_exploding <= 1'b0;
      r_b1           <= '0;
`ifdef BOMB_CROSS_EN
      r_b2           <= '0;
`endif
    end else begin
      r_state        <= w_nstate;
      r_cnt          <= w_ncnt;
      r_drop_d       <= bomb_drop;
      r_tileX        <= w_ntileX;
      r_tileY        <= w_ntileY;
      bomb_armed     <= (w_nstate == S_ARMED);
      bomb_exploding <= (w_nstate == S_EXPLODE);
      // Zero origin lies outside the play field, so collision logic never sees a stale blast.
      r_b1           <= (w_nstate == S_EXPLODE) ? w_r1 : '0;
`ifdef BOMB_CROSS_EN
      r_b2           <= (w_nstate == S_EXPLODE) ? w_r2 : '0;
`endif
    end
  end

  assign bomb_tileX = r_tileX;
  assign bomb_tileY = r_tileY;
  assign bomb1X     = r_b1.x;
  assign bomb1Y     = r_b1.y;
  assign bomb1XS    = r_b1.xs;
  assign bomb1YS    = r_b1.ys;
`ifdef BOMB_CROSS_EN
  assign bomb2X     = r_b2.x;
  assign bomb2Y     = r_b2.y;
  assign bomb2XS    = r_b2.xs;
  assign bomb2YS    = r_b2.ys;
`endif

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb_bomb_ctrl: directed scenarios plus random drop/detonate traffic against a timestamp-based bomb model.
module tb_bomb_ctrl;
  localparam int FUSE = 120, BLAST = 30, COOL = 30, R = 1;
  localparam int XMIN = 32, XMAX = 575, YMIN = 32, YMAX = 447, UW = 19, UH = 26;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b0;
  logic       bomb_drop = 1'b0;
  logic       ext_detonate = 1'b0;
  logic [9:0] userX = '0, userY = '0;
  logic       bomb_armed, bomb_exploding;
  logic [9:0] bomb_tileX, bomb_tileY, bomb1X, bomb1Y, bomb1XS, bomb1YS;
`ifdef BOMB_CROSS_EN
  logic [9:0] bomb2X, bomb2Y, bomb2XS, bomb2YS;
`endif

  bomb_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .bomb_drop(bomb_drop), .ext_detonate(ext_detonate),
    .userX(userX), .userY(userY), .bomb_armed(bomb_armed), .bomb_exploding(bomb_exploding),
    .bomb_tileX(bomb_tileX), .bomb_tileY(bomb_tileY),
    .bomb1X(bomb1X), .bomb1Y(bomb1Y), .bomb1XS(bomb1XS), .bomb1YS(bomb1YS)
`ifdef BOMB_CROSS_EN
    , .bomb2X(bomb2X), .bomb2Y(bomb2Y), .bomb2XS(bomb2XS), .bomb2YS(bomb2YS)
`endif
  );

  always #5 frame_clk = ~frame_clk;

  int n_tests = 0, n_fail = 0;

  // Model: a bomb is a set of frame timestamps; phases follow from comparisons against them.
  int fr;
  bit m_act, m_prev;
  int t_arm, t_exp, t_cool, t_idle, m_tx, m_ty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (frame %0d): got %0d expected %0d", tag, fr, obs, exp);
    end
  endtask

  function automatic int lo_c(input int t, input int lim);
    int v;
    v = t - R * 32;
    return (v < lim) ? lim : v;
  endfunction

  function automatic int hi_c(input int t, input int lim);
    int v;
    v = t + (R + 1) * 32 - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_reset();
    m_act = 0; m_prev = 0; fr = 0;
  endtask

  task automatic set_times(input int te);
    t_exp = te; t_cool = te + BLAST; t_idle = t_cool + COOL;
  endtask

  task automatic model_tick(input bit d, input bit e, input int ux, input int uy);
    bit idle, armed;
    idle  = !m_act || fr >= t_idle;
    armed = m_act && fr >= t_arm && fr < t_exp;
    if (idle && d && !m_prev) begin
      m_act = 1; t_arm = fr + 1; set_times(fr + 1 + FUSE);
      m_tx = ((ux + UW / 2) % 1024) / 32 * 32;
      m_ty = ((uy + UH / 2) % 1024) / 32 * 32;
    end else if (armed && e) begin
      set_times(fr + 1);
    end
    m_prev = d;
    fr++;
  endtask

  task automatic check_model();
    bit ea, ee;
    int x1, y1, xs1, ys1;
`ifdef BOMB_CROSS_EN
    int x2, y2, xs2, ys2;
    x2 = 0; y2 = 0; xs2 = 0; ys2 = 0;
`endif
    ea = m_act && fr >= t_arm && fr < t_exp;
    ee = m_act && fr >= t_exp && fr < t_cool;
    x1 = 0; y1 = 0; xs1 = 0; ys1 = 0;
    if (ee) begin
`ifdef BOMB_CROSS_EN
      x1 = lo_c(m_tx, XMIN); xs1 = hi_c(m_tx, XMAX) - x1; y1 = m_ty; ys1 = 31;
      x2 = m_tx; xs2 = 31; y2 = lo_c(m_ty, YMIN); ys2 = hi_c(m_ty, YMAX) - y2;
`else
      x1 = lo_c(m_tx, XMIN); xs1 = hi_c(m_tx, XMAX) - x1;
      y1 = lo_c(m_ty, YMIN); ys1 = hi_c(m_ty, YMAX) - y1;
`endif
    end
    chk("armed", bomb_armed, ea);
    chk("exploding", bomb_exploding, ee);
    if (ea || ee) begin
      chk("tileX", bomb_tileX, m_tx);
      chk("tileY", bomb_tileY, m_ty);
    end
    chk("b1X", bomb1X, x1); chk("b1Y", bomb1Y, y1);
    chk("b1XS", bomb1XS, xs1); chk("b1YS", bomb1YS, ys1);
`ifdef BOMB_CROSS_EN
    chk("b2X", bomb2X, x2); chk("b2Y", bomb2Y, y2);
    chk("b2XS", bomb2XS, xs2); chk("b2YS", bomb2YS, ys2);
`endif
  endtask

  task automatic step(input bit d, input bit e);
    @(negedge frame_clk);
    check_model();
    bomb_drop = d; ext_detonate = e;
    @(posedge frame_clk); #1;
    model_tick(d, e, userX, userY);
  endtask

  task automatic run(input int n, input bit d, input bit e);
    for (int i = 0; i < n; i++) step(d, e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_armed"}, bomb_armed, 0); chk({tag, "_expl"}, bomb_exploding, 0);
    chk({tag, "_tileX"}, bomb_tileX, 0); chk({tag, "_tileY"}, bomb_tileY, 0);
    chk({tag, "_b1X"}, bomb1X, 0); chk({tag, "_b1Y"}, bomb1Y, 0);
    chk({tag, "_b1XS"}, bomb1XS, 0); chk({tag, "_b1YS"}, bomb1YS, 0);
`ifdef BOMB_CROSS_EN
    chk({tag, "_b2X"}, bomb2X, 0); chk({tag, "_b2Y"}, bomb2Y, 0);
    chk({tag, "_b2XS"}, bomb2XS, 0); chk({tag, "_b2YS"}, bomb2YS, 0);
`endif
  endtask

  task automatic chk_rect(input string tag, input int x, input int y, input int xs, input int ys);
    chk({tag, "_X"}, bomb1X, x); chk({tag, "_Y"}, bomb1Y, y);
    chk({tag, "_XS"}, bomb1XS, xs); chk({tag, "_YS"}, bomb1YS, ys);
  endtask

  int  narm, nexp;
  bit  prev_arm, rd, re;

  initial begin
    #1 Reset = 1'b1;
    #11 chk_all_zero("por");
    @(negedge frame_clk); Reset = 1'b0; model_reset();

    // Spec example: tile (96,224) square blast
    userX = 100; userY = 211;
    step(1, 0);
    chk("t1_tileX", bomb_tileX, 96); chk("t1_tileY", bomb_tileY, 224);
    chk("t1_arm_first", bomb_armed, 1);
    run(FUSE - 1, 0, 0);
    chk("t1_arm_last", bomb_armed, 1);
    step(0, 0);
    chk("t1_exp_first", bomb_exploding, 1);
`ifdef BOMB_CROSS_EN
    chk_rect("t1_h", 64, 224, 95, 31);
`else
    chk_rect("t1_sq", 64, 192, 95, 95);
`endif
    run(BLAST - 1, 0, 0);
    chk("t1_exp_last", bomb_exploding, 1);
    step(0, 0);
    chk("t1_exp_end", bomb_exploding, 0);
    run(COOL, 0, 0);

    // Low-corner clamp
    userX = 23; userY = 19;
    step(1, 0); run(FUSE, 0, 0);
    chk("clamp_expl", bomb_exploding, 1);
`ifdef BOMB_CROSS_EN
    chk_rect("clamp_h", 32, 32, 63, 31);
    chk("clamp_b2Y", bomb2Y, 32); chk("clamp_b2YS", bomb2YS, 63);
`else
    chk_rect("clamp_sq", 32, 32, 63, 63);
`endif
    run(BLAST + COOL, 0, 0);

    // Held key: exactly one cycle, re-press re-arms
    userX = 10'($urandom_range(XMIN, XMAX - UW)); userY = 10'($urandom_range(YMIN, YMAX - UH));
    narm = 0; nexp = 0; prev_arm = 0;
    for (int i = 0; i < 400; i++) begin
      step(1, 0);
      if (bomb_armed && !prev_arm) narm++;
      prev_arm = bomb_armed;
      if (bomb_exploding) nexp++;
    end
    chk("held_arm_cycles", narm, 1);
    chk("held_exp_frames", nexp, BLAST);
    step(0, 0); step(1, 0);
    chk("repress_armed", bomb_armed, 1);
    run(FUSE + BLAST + COOL + 5, 0, 0);

    // Chain detonation on ARMED frame 10
    step(1, 0); run(9, 0, 0);
    chk("ext_pre_armed", bomb_armed, 1);
    step(0, 1);
    chk("ext_expl_next", bomb_exploding, 1); chk("ext_armed_off", bomb_armed, 0);
    nexp = 1;
    for (int i = 0; i < 40; i++) begin
      step(0, 1);
      if (bomb_exploding) nexp++;
    end
    chk("ext_exp_frames", nexp, BLAST);
    run(COOL, 0, 0);

    // Async reset mid-ARMED
    userX = 10'($urandom_range(XMIN, XMAX - UW)); userY = 10'($urandom_range(YMIN, YMAX - UH));
    step(1, 0); run($urandom_range(1, FUSE - 5), 0, 0);
    chk("pre_rst_armed", bomb_armed, 1);
    @(negedge frame_clk); #2 Reset = 1'b1; #1;
    chk_all_zero("async_rst");
    bomb_drop = 0; ext_detonate = 0;
    @(negedge frame_clk); @(negedge frame_clk); Reset = 1'b0; model_reset();
    step(1, 0);
    chk("rst_rearm", bomb_armed, 1);
    run(FUSE + BLAST + COOL + 5, 0, 0);

    // Tile (288,224); drops during COOL are discarded
    userX = 279; userY = 211;
    step(1, 0); run(FUSE, 0, 0);
`ifdef BOMB_CROSS_EN
    chk_rect("cross_b1", 256, 224, 95, 31);
    chk("cross_b2X", bomb2X, 288); chk("cross_b2Y", bomb2Y, 192);
    chk("cross_b2XS", bomb2XS, 31); chk("cross_b2YS", bomb2YS, 95);
`else
    chk_rect("t288_sq", 256, 192, 95, 95);
`endif
    run(BLAST, 0, 0);
    step(1, 0); step(0, 0); step(1, 0); step(0, 0);
    chk("cool_drop_ignored", bomb_armed, 0);
    run(COOL, 0, 0);

    // Random traffic
    rd = 0; re = 0;
    for (int i = 0; i < 3000; i++) begin
      userX = 10'($urandom_range(XMIN, XMAX - UW));
      userY = 10'($urandom_range(YMIN, YMAX - UH));
      if ($urandom_range(0, 7) == 0) rd = ~rd;
      re = ($urandom_range(0, 19) == 0);
      step(rd, re);
    end
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
